// File: rtl/clic_dispatch.sv
// Purpose: offers the winning CLIC candidate to the core, clears taken vectors, nests preempted contexts.
// Latency: eligible req -> irq one cycle later; ack -> threshold/clear one cycle later; one cooldown cycle after each take.
// Backpressure: irq is held until core_ack, a withdrawal or a loss of eligibility; candidates are ignored during cooldown.
module clic_dispatch #(
    parameter int NR_PRIO_BITS  = 3,
    parameter int NR_INDEX_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [NR_INDEX_BITS-1:0] req_index,
    input  logic [NR_PRIO_BITS-1:0]  req_prio,
    input  logic                     core_ack,
    input  logic                     core_ret,
    output logic                     irq,
    output logic [NR_INDEX_BITS-1:0] irq_index,
    output logic [NR_PRIO_BITS-1:0]  irq_prio,
    output logic                     clear_valid,
    output logic [NR_INDEX_BITS-1:0] clear_index,
    output logic [NR_PRIO_BITS-1:0]  threshold,
    output logic [NR_INDEX_BITS-1:0] active_index,
    output logic [NR_PRIO_BITS-1:0]  depth,
    output logic                     ret_err
);

    // Every push strictly raises the threshold, so one slot per non-zero priority suffices.
    localparam int STACK = 2**NR_PRIO_BITS - 1;
    localparam logic [NR_PRIO_BITS-1:0] STACK_FULL = NR_PRIO_BITS'(STACK);

    typedef enum logic [1:0] {IDLE, OFFER, COOLDOWN} state_t;

    state_t                   state, state_n;
    logic [NR_PRIO_BITS-1:0]  stk_prio  [STACK];
    logic [NR_INDEX_BITS-1:0] stk_index [STACK];

    logic                     eligible;
    logic                     push;
    logic                     irq_n, clear_valid_n, ret_err_n;
    logic [NR_INDEX_BITS-1:0] irq_index_n, clear_index_n, active_index_n;
    logic [NR_PRIO_BITS-1:0]  irq_prio_n, threshold_n, depth_n;

    // A candidate may preempt only if it beats the running priority; priority 0 never does.
    always_comb eligible = req_valid && (req_prio > threshold);

    // Next-state and output decode; a return always wins over an ack in the same cycle.
    always_comb begin
        state_n        = state;
        push           = 1'b0;
        irq_n          = irq;
        irq_index_n    = irq_index;
        irq_prio_n     = irq_prio;
        clear_valid_n  = 1'b0;
        clear_index_n  = clear_index;
        threshold_n    = threshold;
        active_index_n = active_index;
        depth_n        = depth;
        ret_err_n      = 1'b0;

        if (core_ret) begin
            if (depth != '0) begin
                threshold_n    = stk_prio[depth - 1'b1];
                active_index_n = stk_index[depth - 1'b1];
                depth_n        = depth - 1'b1;
            end else begin
                ret_err_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (eligible) begin
                    irq_n       = 1'b1;
                    irq_index_n = req_index;
                    irq_prio_n  = req_prio;
                    state_n     = OFFER;
                end
            end
            OFFER: begin
                if (core_ack && !core_ret) begin
                    // Core has taken the offer as presented this cycle: nest and retire it.
                    push           = 1'b1;
                    threshold_n    = irq_prio;
                    active_index_n = irq_index;
                    depth_n        = depth + 1'b1;
                    clear_valid_n  = 1'b1;
                    clear_index_n  = irq_index;
                    irq_n          = 1'b0;
                    state_n        = COOLDOWN;
                end else if (!eligible) begin
                    irq_n   = 1'b0;
                    state_n = IDLE;
                end else if (req_prio > irq_prio) begin
                    irq_index_n = req_index;
                    irq_prio_n  = req_prio;
                end
            end
            COOLDOWN: begin
                irq_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                irq_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Registered outputs; reset discards the nesting context.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq          <= 1'b0;
            irq_index    <= '0;
            irq_prio     <= '0;
            clear_valid  <= 1'b0;
            clear_index  <= '0;
            threshold    <= '0;
            active_index <= '0;
            depth        <= '0;
            ret_err      <= 1'b0;
        end else begin
            irq          <= irq_n;
            irq_index    <= irq_index_n;
            irq_prio     <= irq_prio_n;
            clear_valid  <= clear_valid_n;
            clear_index  <= clear_index_n;
            threshold    <= threshold_n;
            active_index <= active_index_n;
            depth        <= depth_n;
            ret_err      <= ret_err_n;
        end
    end

    // Stack storage; entries above depth are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stk_prio[depth]  <= threshold;
            stk_index[depth] <= active_index;
        end
    end

    // Overflow is structurally impossible; flag it if it ever happens.
    assert property (@(posedge clk) disable iff (reset) !(push && depth == STACK_FULL));

endmodule

// File: tb/tb_clic_dispatch.sv
// Purpose: directed scoreboard bench for clic_dispatch (offer, nesting, blocking, upgrade, ret/ack race, reset).
// Latency: expectations are checked one cycle after the inputs that cause them.
// Backpressure: none; the bench drives core_ack/core_ret directly.
module tb_clic_dispatch;

    typedef struct packed {
        logic       irq;
        logic [1:0] irq_index;
        logic [2:0] irq_prio;
        logic       clear_valid;
        logic [1:0] clear_index;
        logic [2:0] threshold;
        logic [1:0] active_index;
        logic [2:0] depth;
        logic       ret_err;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_index;
    logic [2:0] req_prio;
    logic       core_ack;
    logic       core_ret;
    logic       irq;
    logic [1:0] irq_index;
    logic [2:0] irq_prio;
    logic       clear_valid;
    logic [1:0] clear_index;
    logic [2:0] threshold;
    logic [1:0] active_index;
    logic [2:0] depth;
    logic       ret_err;

    obs_t  obs;
    obs_t  exp_q [$];
    string tag_q [$];
    int    compared   = 0;
    int    mismatched = 0;

    clic_dispatch #(.NR_PRIO_BITS(3), .NR_INDEX_BITS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .req_prio     (req_prio),
        .core_ack     (core_ack),
        .core_ret     (core_ret),
        .irq          (irq),
        .irq_index    (irq_index),
        .irq_prio     (irq_prio),
        .clear_valid  (clear_valid),
        .clear_index  (clear_index),
        .threshold    (threshold),
        .active_index (active_index),
        .depth        (depth),
        .ret_err      (ret_err)
    );

    always #5 clk = ~clk;

    assign obs = {irq, irq_index, irq_prio, clear_valid, clear_index,
                  threshold, active_index, depth, ret_err};

    function automatic obs_t mk(input logic i, input logic [1:0] ii, input logic [2:0] ip,
                                input logic cv, input logic [1:0] ci, input logic [2:0] thr,
                                input logic [1:0] act, input logic [2:0] dep, input logic err);
        obs_t r;
        r = {i, ii, ip, cv, ci, thr, act, dep, err};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] idx, input logic [2:0] pr,
                         input logic ack, input logic ret);
        req_valid = v;
        req_index = idx;
        req_prio  = pr;
        core_ack  = ack;
        core_ret  = ret;
    endtask

    // Queue the expectation, advance one edge, then compare what the DUT produced.
    // Offer fields only matter while irq is up, clear_index only while clear_valid is up,
    // unless strict is set (reset checks cover every bit).
    task automatic cyc(input string tag, input obs_t e, input bit strict);
        obs_t  o;
        obs_t  x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        o = obs;
        if (!strict) begin
            if (!x.irq) begin
                o.irq_index = '0; o.irq_prio = '0;
                x.irq_index = '0; x.irq_prio = '0;
            end
            if (!x.clear_valid) begin
                o.clear_index = '0;
                x.clear_index = '0;
            end
        end
        compared++;
        assert (o === x) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (irq,idx,prio,clr,cidx,thr,act,depth,err)", t, o, x);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc("reset0", mk(0,0,0, 0,0, 0,0,0, 0), 1'b1);
        cyc("reset1", mk(0,0,0, 0,0, 0,0,0, 0), 1'b1);
        reset = 1'b0;

        // Basic offer/ack, cooldown, earliest re-offer at ack+3.
        drive(1, 2, 5, 0, 0);
        cyc("t1_offer",  mk(1,2,5, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 2, 5, 1, 0);
        cyc("t1_ack",    mk(0,0,0, 1,2, 5,2,1, 0), 1'b0);
        drive(1, 3, 7, 0, 0);
        cyc("t1_cool",   mk(0,0,0, 0,0, 5,2,1, 0), 1'b0);
        cyc("t1_irq_m3", mk(1,3,7, 0,0, 5,2,1, 0), 1'b0);
        drive(0, 3, 7, 0, 0);
        cyc("t1_wd",     mk(0,0,0, 0,0, 5,2,1, 0), 1'b0);

        // Blocking by the running threshold.
        drive(1, 1, 5, 0, 0);
        cyc("blk_eq",    mk(0,0,0, 0,0, 5,2,1, 0), 1'b0);
        drive(1, 1, 4, 0, 0);
        cyc("blk_lo",    mk(0,0,0, 0,0, 5,2,1, 0), 1'b0);
        drive(0, 0, 0, 0, 1);
        cyc("ret1",      mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);
        cyc("ret_err0",  mk(0,0,0, 0,0, 0,0,0, 1), 1'b0);
        drive(1, 1, 0, 0, 0);
        cyc("blk_p0",    mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);

        // Two-level nesting and unwinding.
        drive(1, 1, 3, 0, 0);
        cyc("n_off1",    mk(1,1,3, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 1, 3, 1, 0);
        cyc("n_ack1",    mk(0,0,0, 1,1, 3,1,1, 0), 1'b0);
        drive(1, 2, 6, 0, 0);
        cyc("n_cool1",   mk(0,0,0, 0,0, 3,1,1, 0), 1'b0);
        cyc("n_off2",    mk(1,2,6, 0,0, 3,1,1, 0), 1'b0);
        drive(1, 2, 6, 1, 0);
        cyc("n_ack2",    mk(0,0,0, 1,2, 6,2,2, 0), 1'b0);
        drive(0, 0, 0, 0, 0);
        cyc("n_cool2",   mk(0,0,0, 0,0, 6,2,2, 0), 1'b0);
        drive(0, 0, 0, 0, 1);
        cyc("n_ret1",    mk(0,0,0, 0,0, 3,1,1, 0), 1'b0);
        cyc("n_ret2",    mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);
        cyc("n_ret3",    mk(0,0,0, 0,0, 0,0,0, 1), 1'b0);
        drive(0, 0, 0, 1, 0);
        cyc("ack_idle",  mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);

        // Upgrade only on strictly higher priority, then withdraw.
        drive(1, 1, 2, 0, 0);
        cyc("u_off",     mk(1,1,2, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 3, 7, 0, 0);
        cyc("u_up",      mk(1,3,7, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 2, 7, 0, 0);
        cyc("u_eq",      mk(1,3,7, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 0, 4, 0, 0);
        cyc("u_lo",      mk(1,3,7, 0,0, 0,0,0, 0), 1'b0);
        drive(0, 0, 4, 0, 0);
        cyc("u_wd",      mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);

        // Return and ack in the same cycle: return wins, offer stays up.
        drive(1, 1, 4, 0, 0);
        cyc("s_off1",    mk(1,1,4, 0,0, 0,0,0, 0), 1'b0);
        drive(1, 1, 4, 1, 0);
        cyc("s_ack1",    mk(0,0,0, 1,1, 4,1,1, 0), 1'b0);
        drive(1, 2, 6, 0, 0);
        cyc("s_cool",    mk(0,0,0, 0,0, 4,1,1, 0), 1'b0);
        cyc("s_off2",    mk(1,2,6, 0,0, 4,1,1, 0), 1'b0);
        drive(1, 2, 6, 1, 1);
        cyc("s_both",    mk(1,2,6, 0,0, 0,0,0, 0), 1'b0);
        drive(0, 0, 0, 0, 0);
        cyc("s_wd",      mk(0,0,0, 0,0, 0,0,0, 0), 1'b0);

        // Nest to depth 3, reset during the next offer.
        for (int k = 1; k <= 3; k++) begin
            drive(1, 2'(k), 3'(k), 0, 0);
            cyc($sformatf("r_off%0d", k),  mk(1,2'(k),3'(k), 0,0, 3'(k-1),2'(k-1),3'(k-1), 0), 1'b0);
            drive(1, 2'(k), 3'(k), 1, 0);
            cyc($sformatf("r_ack%0d", k),  mk(0,0,0, 1,2'(k), 3'(k),2'(k),3'(k), 0), 1'b0);
            drive(1, 2'(k), 3'(k), 0, 0);
            cyc($sformatf("r_cool%0d", k), mk(0,0,0, 0,0, 3'(k),2'(k),3'(k), 0), 1'b0);
        end
        drive(1, 0, 5, 0, 0);
        cyc("r_off4",    mk(1,0,5, 0,0, 3,3,3, 0), 1'b0);
        reset = 1'b1;
        cyc("r_rst",     mk(0,0,0, 0,0, 0,0,0, 0), 1'b1);
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        cyc("r_ret",     mk(0,0,0, 0,0, 0,0,0, 1), 1'b0);
        drive(0, 0, 0, 0, 0);
        cyc("r_end",     mk(0,0,0, 0,0, 0,0,0, 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
